// File: rtl/sprite_anim_render_if.sv
// Sprite ROM and palette bus between the sprite renderer and its lookup memories.
// The renderer (master) drives the ROM address and the palette index; the
// memory side (slave) returns the ROM colour index and the palette colour.
interface sprite_anim_render_if #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4
);
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_data;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;

    modport master (
        output rom_addr,
        output pal_index,
        input  rom_data,
        input  pal_red,
        input  pal_green,
        input  pal_blue
    );

    modport slave (
        input  rom_addr,
        input  pal_index,
        output rom_data,
        output pal_red,
        output pal_green,
        output pal_blue
    );
endinterface

// File: rtl/sprite_anim_render.sv
// Sprite pixel pipeline: hit test and ROM address build, synchronous ROM read,
// palette lookup with transparency, and a frame sequencer that steps the
// animation on frame-start pulses (looping or one-shot).
module sprite_anim_render #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 96,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD       = 6,
    parameter int ADDR_W     = 16,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int COORD_W    = 10,
    localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                rst_n,
    input  logic [COORD_W-1:0]  draw_x,
    input  logic [COORD_W-1:0]  draw_y,
    input  logic                blank,
    input  logic                frame_start,
    input  logic [COORD_W-1:0]  sprite_x,
    input  logic [COORD_W-1:0]  sprite_y,
    input  logic                flip,
    input  logic                anim_en,
    input  logic                loop_mode,
    input  logic                anim_restart,
    sprite_anim_render_if.master mem,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                opaque,
    output logic [FRAME_W-1:0]  anim_frame,
    output logic                anim_done
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    // Linear ROM address: frames stored back to back, rows of SPR_W pixels.
    function automatic logic [ADDR_W-1:0] sprite_addr(
        input logic [FRAME_W-1:0] frame,
        input int                 row,
        input int                 ccol
    );
        int full;
        full = int'(frame) * SPR_W * SPR_H + row * SPR_W + ccol;
        return ADDR_W'(full);
    endfunction

    logic signed [COORD_W:0] col_p0;
    logic signed [COORD_W:0] row_p0;
    int                      col_i;
    int                      row_i;
    int                      ccol_i;
    logic                    hit_p0;
    logic [ADDR_W-1:0]       addr_p0;
    logic                    vld_p1;
    logic                    vld_p2;
    logic [HOLD_W-1:0]       hold;
    logic [HOLD_W-1:0]       hold_next;
    logic [FRAME_W-1:0]      frame_next;
    logic                    done_next;

    // Stage 0: sprite-relative position, hit test and mirrored ROM address.
    // Differences are one bit wider than the coordinates so a pixel left of or
    // above the sprite shows up as negative instead of wrapping into the box.
    always_comb begin
        col_p0  = $signed({1'b0, draw_x}) - $signed({1'b0, sprite_x});
        row_p0  = $signed({1'b0, draw_y}) - $signed({1'b0, sprite_y});
        col_i   = int'(col_p0);
        row_i   = int'(row_p0);
        hit_p0  = blank && (col_i >= 0) && (col_i < SPR_W) &&
                  (row_i >= 0) && (row_i < SPR_H);
        ccol_i  = flip ? (SPR_W - 1 - col_i) : col_i;
        addr_p0 = sprite_addr(anim_frame, row_i, ccol_i);
    end

    // Stage 1: register the ROM address (held on a miss) and the hit flag.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.rom_addr <= '0;
            vld_p1       <= 1'b0;
        end else begin
            vld_p1 <= hit_p0;
            if (hit_p0) begin
                mem.rom_addr <= addr_p0;
            end
        end
    end

    // Stage 2: the ROM output register carries the colour index; track its hit.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    assign mem.pal_index = mem.rom_data;

    // Stage 3: registered colour; transparent or missed pixels come out black.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            red    <= 4'd0;
            green  <= 4'd0;
            blue   <= 4'd0;
            opaque <= 1'b0;
        end else if (vld_p2 && (mem.rom_data != IDX_W'(TRANSP_IDX))) begin
            red    <= mem.pal_red;
            green  <= mem.pal_green;
            blue   <= mem.pal_blue;
            opaque <= 1'b1;
        end else begin
            red    <= 4'd0;
            green  <= 4'd0;
            blue   <= 4'd0;
            opaque <= 1'b0;
        end
    end

    // Frame sequencer next state: restart wins; otherwise only frame_start moves it.
    always_comb begin
        frame_next = anim_frame;
        hold_next  = hold;
        done_next  = anim_done;
        if (anim_restart) begin
            frame_next = '0;
            hold_next  = '0;
            done_next  = 1'b0;
        end else if (frame_start && anim_en && !anim_done) begin
            if (hold == HOLD_W'(HOLD - 1)) begin
                hold_next = '0;
                if (anim_frame != FRAME_W'(NUM_FRAMES - 1)) begin
                    frame_next = anim_frame + FRAME_W'(1);
                end else if (loop_mode) begin
                    frame_next = '0;
                end else begin
                    done_next = 1'b1;
                end
            end else begin
                hold_next = hold + HOLD_W'(1);
            end
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_frame <= '0;
            hold       <= '0;
            anim_done  <= 1'b0;
        end else begin
            anim_frame <= frame_next;
            hold       <= hold_next;
            anim_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_sprite_anim_render.sv
// Bench for sprite_anim_render: directed pixel/sequencer scenarios followed by
// randomized traffic, all compared against a behavioural model of the sprite.
module tb_sprite_anim_render;

    localparam int SPR_W      = 64;
    localparam int SPR_H      = 96;
    localparam int NF         = 4;
    localparam int HOLD       = 6;
    localparam int ADDR_W     = 16;
    localparam int IDX_W      = 4;
    localparam int TRANSP     = 0;
    localparam int COORD_W    = 10;
    localparam int FRAME_W    = 2;
    localparam int ROM_SZ     = NF * SPR_W * SPR_H;

    logic               vga_clk;
    logic               rst_n;
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic               blank;
    logic               frame_start;
    logic [COORD_W-1:0] sprite_x;
    logic [COORD_W-1:0] sprite_y;
    logic               flip;
    logic               anim_en;
    logic               loop_mode;
    logic               anim_restart;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               opaque;
    logic [FRAME_W-1:0] anim_frame;
    logic               anim_done;

    logic [IDX_W-1:0]   rom_mem [0:ROM_SZ-1];
    logic [11:0]        pal_tab [0:15];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_frame;
    int          m_hold;
    bit          m_done;
    int          m_addr;
    logic [12:0] exp_q[$];

    sprite_anim_render_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    sprite_anim_render #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .HOLD(HOLD),
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .TRANSP_IDX(TRANSP), .COORD_W(COORD_W)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .draw_x(draw_x), .draw_y(draw_y),
        .blank(blank), .frame_start(frame_start), .sprite_x(sprite_x),
        .sprite_y(sprite_y), .flip(flip), .anim_en(anim_en),
        .loop_mode(loop_mode), .anim_restart(anim_restart), .mem(bus.master),
        .red(red), .green(green), .blue(blue), .opaque(opaque),
        .anim_frame(anim_frame), .anim_done(anim_done)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // External synchronous sprite ROM and combinational palette
    always @(posedge vga_clk) bus.rom_data <= rom_mem[bus.rom_addr];
    assign bus.pal_red   = pal_tab[bus.pal_index][11:8];
    assign bus.pal_green = pal_tab[bus.pal_index][7:4];
    assign bus.pal_blue  = pal_tab[bus.pal_index][3:0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame = 0;
        m_hold  = 0;
        m_done  = 0;
        m_addr  = 0;
        exp_q.delete();
        exp_q.push_back(13'd0);
        exp_q.push_back(13'd0);
    endtask

    // Model the current inputs, advance one clock, then compare everything.
    task automatic step();
        int col, row, cc, a;
        bit hit;
        logic [12:0] px;
        col = int'(draw_x) - int'(sprite_x);
        row = int'(draw_y) - int'(sprite_y);
        hit = blank && col >= 0 && col < SPR_W && row >= 0 && row < SPR_H;
        cc  = flip ? (SPR_W - 1 - col) : col;
        a   = (m_frame * SPR_W * SPR_H + row * SPR_W + cc) % (1 << ADDR_W);
        px  = 13'd0;
        if (hit) begin
            m_addr = a;
            if (rom_mem[a] != IDX_W'(TRANSP)) px = {1'b1, pal_tab[rom_mem[a]]};
        end
        exp_q.push_back(px);
        if (anim_restart) begin
            m_frame = 0; m_hold = 0; m_done = 0;
        end else if (frame_start && anim_en && !m_done) begin
            if (m_hold == HOLD - 1) begin
                m_hold = 0;
                if (m_frame < NF - 1) m_frame = m_frame + 1;
                else if (loop_mode) m_frame = 0;
                else m_done = 1;
            end else begin
                m_hold = m_hold + 1;
            end
        end
        @(posedge vga_clk);
        #1;
        check_val("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        check_val("anim_frame", 32'(anim_frame), 32'(m_frame));
        check_val("anim_done", 32'(anim_done), 32'(m_done));
        if (exp_q.size() >= 3) begin
            px = exp_q.pop_front();
            check_val("pixel", 32'({opaque, red, green, blue}), 32'(px));
        end
    endtask

    task automatic draw(input int x, input int y, input bit b);
        draw_x = COORD_W'(x);
        draw_y = COORD_W'(y);
        blank  = b;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
    endtask

    task automatic rand_inputs(input int i);
        int t;
        if (i % 64 == 0) begin
            sprite_x  = COORD_W'($urandom_range(0, 1023));
            sprite_y  = COORD_W'($urandom_range(0, 1023));
            flip      = 1'($urandom_range(0, 1));
            loop_mode = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 3) == 0) begin
            draw_x = COORD_W'($urandom_range(0, 1023));
            draw_y = COORD_W'($urandom_range(0, 1023));
        end else begin
            t = int'(sprite_x) + int'($urandom_range(0, SPR_W + 7)) - 4;
            draw_x = COORD_W'(t);
            t = int'(sprite_y) + int'($urandom_range(0, SPR_H + 7)) - 4;
            draw_y = COORD_W'(t);
        end
        blank        = ($urandom_range(0, 9) != 0);
        frame_start  = ($urandom_range(0, 19) == 0);
        anim_en      = ($urandom_range(0, 9) != 0);
        anim_restart = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < ROM_SZ; i++) begin
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
        for (int i = 0; i < 16; i++) pal_tab[i] = 12'($urandom_range(0, 4095));
        pal_tab[5] = 12'hF82;
        rom_mem[0]  = 4'd3;
        rom_mem[63] = 4'd7;

        rst_n = 1'b0;
        draw(0, 0, 1'b0);
        frame_start = 0; sprite_x = 0; sprite_y = 0; flip = 0;
        anim_en = 0; loop_mode = 1; anim_restart = 0;
        #2;
        check_val("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check_val("rst_rgb", 32'({red, green, blue}), 32'd0);
        check_val("rst_opaque", 32'(opaque), 32'd0);
        check_val("rst_frame", 32'(anim_frame), 32'd0);
        check_val("rst_done", 32'(anim_done), 32'd0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        model_reset();

        // Unflipped sprite at (100,50): edge columns hit, neighbours miss
        sprite_x = 10'd100; sprite_y = 10'd50;
        draw(100, 50, 1'b1); step();
        check_val("addr_first", 32'(bus.rom_addr), 32'd0);
        draw(163, 50, 1'b1); step();
        check_val("addr_last_col", 32'(bus.rom_addr), 32'd63);
        draw(164, 50, 1'b1); step();
        check_val("addr_hold_miss", 32'(bus.rom_addr), 32'd63);
        check_val("first_pixel_lat", 32'({opaque, red, green, blue}), {19'd0, 1'b1, pal_tab[3]});
        draw(99, 50, 1'b1); step();
        check_val("last_col_pixel", 32'({opaque, red, green, blue}), {19'd0, 1'b1, pal_tab[7]});
        draw(110, 60, 1'b0); step();
        check_val("right_miss_pixel", 32'(opaque), 32'd0);
        draw(0, 0, 1'b0); step();
        check_val("left_miss_pixel", 32'(opaque), 32'd0);
        step();
        check_val("blank_pixel", 32'({opaque, red, green, blue}), 32'd0);

        // Mirrored row 1: transparent index, then an opaque colour
        flip = 1'b1;
        rom_mem[127] = 4'd0;
        draw(100, 51, 1'b1); step();
        check_val("flip_addr", 32'(bus.rom_addr), 32'd127);
        draw(0, 0, 1'b0); step(); step();
        check_val("transp_pixel", 32'({opaque, red, green, blue}), 32'd0);
        step();
        rom_mem[127] = 4'd5;
        draw(100, 51, 1'b1); step();
        draw(0, 0, 1'b0); step(); step();
        check_val("flip_rgb", 32'({opaque, red, green, blue}), 32'h1F82);
        step();
        flip = 1'b0;

        // Looping sequencer: frames 0..3 every HOLD pulses, then wrap
        anim_restart = 1'b1; step(); anim_restart = 1'b0;
        anim_en = 1'b1; loop_mode = 1'b1;
        for (int p = 1; p <= 4 * HOLD; p++) begin
            pulse_frame();
            check_val("loop_frame", 32'(anim_frame), 32'((p / HOLD) % NF));
            if (p == 2 * HOLD) begin
                draw(100, 50, 1'b1); step();
                check_val("frame2_addr", 32'(bus.rom_addr), 32'd12288);
                draw(0, 0, 1'b0);
            end
        end

        // One-shot: stop on last frame, then restart together with frame_start
        anim_restart = 1'b1; step(); anim_restart = 1'b0;
        loop_mode = 1'b0;
        for (int p = 0; p < 4 * HOLD; p++) pulse_frame();
        check_val("oneshot_frame", 32'(anim_frame), 32'd3);
        check_val("oneshot_done", 32'(anim_done), 32'd1);
        for (int p = 0; p < HOLD; p++) pulse_frame();
        check_val("oneshot_stays", 32'({anim_done, anim_frame}), 32'h7);
        anim_restart = 1'b1; frame_start = 1'b1; step();
        anim_restart = 1'b0; frame_start = 1'b0;
        check_val("restart_frame", 32'(anim_frame), 32'd0);
        check_val("restart_done", 32'(anim_done), 32'd0);
        for (int p = 0; p < HOLD - 1; p++) pulse_frame();
        check_val("restart_hold_cleared", 32'(anim_frame), 32'd0);
        pulse_frame();
        check_val("restart_advance", 32'(anim_frame), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(i);
            step();
        end

        // Asynchronous reset while a sprite pixel is being shown
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            rand_inputs(i);
            anim_restart = 1'b0;
            step();
            if (opaque) found = 1;
        end
        check_val("opaque_seen", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rgb", 32'({opaque, red, green, blue}), 32'd0);
        check_val("async_rom_addr", 32'(bus.rom_addr), 32'd0);
        check_val("async_anim", 32'({anim_done, anim_frame}), 32'd0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 300; i++) begin
            rand_inputs(i);
            step();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_anim_render.md
Name: sprite_anim_render

Overview:
- Parametrised sprite pixel pipeline. From the current VGA draw coordinate it computes a hit test against a positioned sprite box, builds the sprite ROM address (animation frame, row, optionally mirrored column) and reads an external synchronous sprite ROM.
- It maps the colour index through an external combinational palette and emits registered 4-bit RGB plus an opaque flag for the layer mixer.
- An internal frame-sequencer advances animation frames on frame-start pulses, in looping or one-shot mode.

Parameters:
- SPR_W, 64, sprite width in pixels (≥2)
- SPR_H, 96, sprite height in pixels (≥2)
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM (≥1)
- HOLD, 6, video frames each animation frame is shown (≥1)
- ADDR_W, 16, ROM address width; must hold NUM_FRAMES*SPR_W*SPR_H−1
- IDX_W, 4, palette index width
- TRANSP_IDX, 0, palette index treated as transparent
- COORD_W, 10, draw/sprite coordinate width

Ports:
- vga_clk, input, 1, pixel clock; all logic on its rising edge
- rst_n, input, 1, asynchronous active-low reset
- draw_x, input, COORD_W, current pixel column
- draw_y, input, COORD_W, current pixel row
- blank, input, 1, 1 = active video, 0 = blanking
- frame_start, input, 1, one-cycle pulse at start of each video frame
- sprite_x, input, COORD_W, sprite left edge
- sprite_y, input, COORD_W, sprite top edge
- flip, input, 1, 1 = mirror horizontally
- anim_en, input, 1, enable frame advance
- loop_mode, input, 1, 1 = wrap at last frame, 0 = one-shot
- anim_restart, input, 1, one-cycle pulse: restart at frame 0
- rom_addr, output, ADDR_W, registered ROM address
- rom_data, input, IDX_W, ROM output; valid one cycle after rom_addr
- pal_index, output, IDX_W, index to palette (combinational from rom_data)
- pal_red/pal_green/pal_blue, input, 4 each, palette colour for pal_index
- red/green/blue, output, 4 each, registered pixel colour
- opaque, output, 1, sprite pixel drawn this cycle
- anim_frame, output, clog2(NUM_FRAMES) (min 1), current frame
- anim_done, output, 1, one-shot sequence finished

Behaviour:
- Reset (async assert, sync release): rom_addr=0, red/green/blue=0, opaque=0, anim_frame=0, anim_done=0, hold counter=0, all pipeline valid bits=0.
- Stage 1 (cycle N→N+1):
  - col = draw_x−sprite_x, row = draw_y−sprite_y, computed at COORD_W+1 bits.
  - hit = blank & 0≤col<SPR_W & 0≤row<SPR_H. Negative differences are a miss.
  - ccol = flip ? SPR_W−1−col : col.
  - rom_addr <= anim_frame*SPR_W*SPR_H + row*SPR_W + ccol, truncated to ADDR_W. On a miss, rom_addr holds its value.
  - hit1 <= hit.
- Stage 2 (N+1→N+2): rom_data is valid. hit2 <= hit1, idx2 <= rom_data. pal_index = idx2.
- Stage 3 (N+2→N+3):
  - If hit2 & idx2≠TRANSP_IDX: red/green/blue <= pal_*, opaque <= 1.
  - Otherwise: red/green/blue <= 0, opaque <= 0.
  - Total latency from draw_x/draw_y/blank to red/green/blue/opaque is exactly 3 cycles.
- Frame sequencer (updates only on a frame_start cycle, so the frame never changes mid-picture):
  - anim_restart has priority over everything: anim_frame<=0, hold<=0, anim_done<=0. It may arrive on any cycle, including together with frame_start.
  - Otherwise, on frame_start with anim_en=1 and anim_done=0: if hold==HOLD−1, then hold<=0 and the frame advances; else hold<=hold+1.
  - Advance when anim_frame<NUM_FRAMES−1: anim_frame+1.
  - Advance at the last frame with loop_mode=1: anim_frame<=0.
  - Advance at the last frame with loop_mode=0: anim_frame stays, anim_done<=1. anim_done stays high until restart or reset.
  - anim_en=0 freezes both hold and anim_frame.
  - NUM_FRAMES=1: anim_frame is constant 0. One-shot sets anim_done after HOLD pulses.
- The sprite box may extend past screen edges. Only in-range draw coordinates produce pixels; no wrap-around of col/row.
- flip, sprite_x and sprite_y are sampled each cycle in stage 1. Changes take effect on the next pixel.

Test Plan:
- Reset mid-stream with rst_n=0 while opaque=1 → all outputs 0 immediately (async). First opaque pixel no earlier than 3 cycles after release.
- sprite_x=100, sprite_y=50, flip=0, frame 0, draw (100,50) then (163,50) → rom_addr=0 then 63. Pixel at (164,50) and (99,50) → opaque=0, RGB appears exactly 3 cycles later.
- Same sprite with flip=1, draw (100,51) → rom_addr=64+63=127. rom_data=TRANSP_IDX → opaque=0, RGB=0. rom_data=5 with pal_red/green/blue=F,8,2 → red=F, green=8, blue=2, opaque=1.
- blank=0 inside the box → opaque=0, RGB=0 after 3 cycles.
- HOLD=6, NUM_FRAMES=4, loop_mode=1, anim_en=1, 24 frame_start pulses → anim_frame steps 0,1,2,3 every 6 pulses and wraps to 0. At frame 2, row 0, col 0 → rom_addr=2*6144=12288.
- loop_mode=0 → after 24 pulses anim_frame=3, anim_done=1, unchanged by more pulses. anim_restart on the same cycle as frame_start → anim_frame=0, anim_done=0, hold=0.
